sram_1rw1r_ctrl: RTL and testbench

- Initiator-side controller for the 32x256 1RW+1R OpenRAM macro. Converts two valid/ready request streams (port A read/write with byte mask, port B read-only) into macro pin activity (csb/web/wmask/addr/din), captures dout at the correct edge, and returns read data on valid/ready response streams.
- Optional post-reset zero-fill sequencer.
- Sits between the core bus logic and the macro instance; both macro clocks tie to clk.

---
 rtl/sram_ctrl_pkg.sv | 8 +
 rtl/sram_rsp_fifo.sv | 36 +++
 rtl/sram_1rw1r_ctrl.sv | 127 ++++++++++++
 tb/tb_sram_1rw1r_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared widths and controller state for the 1RW+1R SRAM controller.
package sram_ctrl_pkg;
  localparam int SRAM_DATA_W     = 32;
  localparam int SRAM_ADDR_W     = 8;
  localparam int SRAM_NUM_WMASKS = SRAM_DATA_W / 8;

  typedef enum logic {INIT, RUN} state_e;
endpackage

// File: rtl/sram_rsp_fifo.sv
// Two-entry read-response buffer with valid/ready output and occupancy count.
module sram_rsp_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             rvalid,
  input  logic             rready,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       count
);
  logic [1:0][WIDTH-1:0] mem;
  logic                  wptr, rptr;
  logic                  pop;

  assign rvalid = (count != 2'd0);
  assign rdata  = mem[rptr];
  assign pop    = rvalid & rready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wptr] <= push_data;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/sram_1rw1r_ctrl.sv
// Initiator-side controller for a 1RW+1R SRAM macro: request streams in,
// macro pins out, read data returned two cycles after acceptance.
module sram_1rw1r_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_DATA_W,
  parameter int ADDR_WIDTH = SRAM_ADDR_W,
  parameter int NUM_WMASKS = SRAM_NUM_WMASKS,
  parameter bit INIT_ZERO  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_done,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_we,
  input  logic [NUM_WMASKS-1:0] a_wmask,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_rvalid,
  input  logic                  a_rready,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic                  b_rvalid,
  input  logic                  b_rready,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0,
  output logic                  csb1,
  output logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] dout1
);
  state_e                state, state_nxt;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  run;
  logic                  a_rd_q, b_rd_q;
  logic [1:0]            a_cnt, b_cnt;
  logic                  a_fire, b_fire, collide;

  assign run       = (state == RUN) & ~rst;
  assign init_done = run;

  // Credits = buffered + in-flight reads; a same-cycle pop frees one slot.
  assign a_ready = run & (((a_cnt + {1'b0, a_rd_q}) < 2'd2) | (a_rvalid & a_rready));
  assign a_fire  = a_valid & a_ready;

  // Hold B off for one cycle so it reads the data being written this cycle.
  assign collide = a_fire & a_we & b_valid & (b_addr == a_addr);
  assign b_ready = run & ~collide &
                   (((b_cnt + {1'b0, b_rd_q}) < 2'd2) | (b_rvalid & b_rready));
  assign b_fire  = b_valid & b_ready;

  always_comb begin
    state_nxt = state;
    csb0      = 1'b1;
    web0      = 1'b1;
    wmask0    = '0;
    addr0     = '0;
    din0      = '0;
    csb1      = 1'b1;
    addr1     = '0;
    if (!rst) begin
      case (state)
        INIT: begin
          csb0   = 1'b0;
          web0   = 1'b0;
          wmask0 = '1;
          addr0  = init_addr;
          if (init_addr == '1) state_nxt = RUN;
        end
        RUN: begin
          csb0   = ~a_fire;
          web0   = ~a_we;
          wmask0 = a_we ? a_wmask : '0;
          addr0  = a_addr;
          din0   = a_wdata;
          csb1   = ~b_fire;
          addr1  = b_addr;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // rd_q marks the cycle whose closing edge is the only valid dout sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT_ZERO ? INIT : RUN;
      init_addr <= '0;
      a_rd_q    <= 1'b0;
      b_rd_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      if (state == INIT) init_addr <= init_addr + 1'b1;
      a_rd_q <= a_fire & ~a_we;
      b_rd_q <= b_fire;
    end
  end

  sram_rsp_fifo #(.WIDTH(DATA_WIDTH)) u_a_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (a_rd_q),
    .push_data (dout0),
    .rvalid    (a_rvalid),
    .rready    (a_rready),
    .rdata     (a_rdata),
    .count     (a_cnt)
  );

  sram_rsp_fifo #(.WIDTH(DATA_WIDTH)) u_b_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (b_rd_q),
    .push_data (dout1),
    .rvalid    (b_rvalid),
    .rready    (b_rready),
    .rdata     (b_rdata),
    .count     (b_cnt)
  );
endmodule

// File: tb/tb_sram_1rw1r_ctrl.sv
// Directed bench for sram_1rw1r_ctrl with a behavioural 32x256 1RW+1R macro.
module tb_sram_1rw1r_ctrl;
  logic        clk, rst, init_done;
  logic        a_valid, a_ready, a_we, a_rvalid, a_rready;
  logic [3:0]  a_wmask;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic        b_valid, b_ready, b_rvalid, b_rready;
  logic [7:0]  b_addr;
  logic [31:0] b_rdata;
  logic        csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [7:0]  addr0, addr1;
  logic [31:0] din0, dout0, dout1;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] mem [256];
  logic [31:0] pat [8];

  sram_1rw1r_ctrl dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_wmask(a_wmask),
    .a_addr(a_addr), .a_wdata(a_wdata), .a_rvalid(a_rvalid),
    .a_rready(a_rready), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr),
    .b_rvalid(b_rvalid), .b_rready(b_rready), .b_rdata(b_rdata),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(dout0), .csb1(csb1), .addr1(addr1), .dout1(dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro model: dout only holds data for the cycle after a read.
  always @(posedge clk) begin
    if (!csb0) begin
      if (!web0) begin
        for (int k = 0; k < 4; k++)
          if (wmask0[k]) mem[addr0][8*k +: 8] <= din0[8*k +: 8];
        dout0 <= 'x;
      end else begin
        dout0 <= mem[addr0];
      end
    end else begin
      dout0 <= 'x;
    end
    if (!csb1) dout1 <= mem[addr1];
    else       dout1 <= 'x;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [7:0] ad, input logic [31:0] d, input logic [3:0] m);
    a_valid = 1'b1; a_we = 1'b1; a_addr = ad; a_wdata = d; a_wmask = m;
    #3 chk("a_write_ready", {63'd0, a_ready}, 64'd1);
    tick;
    a_valid = 1'b0; a_we = 1'b0;
  endtask

  initial begin
    int bidx, rcv;
    rst = 1'b1;
    a_valid = 0; a_we = 0; a_wmask = 0; a_addr = 0; a_wdata = 0; a_rready = 1;
    b_valid = 0; b_addr = 0; b_rready = 1;

    // Reset values while rst is held
    @(posedge clk); @(posedge clk); #1;
    #3 chk("reset_pins", {csb0, web0, wmask0, addr0, din0, csb1, addr1,
                          a_rvalid, b_rvalid, a_ready, b_ready, init_done},
           {1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b1, 8'h00, 5'b00000});
    tick;

    // Zero-fill: valids held high to show requests are refused
    rst = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      #3 chk("init_write", {csb0, web0, addr0, din0, wmask0, a_ready, b_ready, init_done},
             {1'b0, 1'b0, 8'(i), 32'h0, 4'hF, 3'b000});
      tick;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    #3 chk("init_done_rise", {csb0, init_done, a_ready, b_ready}, 4'b1111);
    tick;

    // Full write then A read: 2-cycle latency
    a_write(8'h10, 32'hDEADBEEF, 4'hF);
    a_valid = 1'b1; a_we = 1'b0; a_addr = 8'h10;
    #3 chk("a_read_ready", {63'd0, a_ready}, 64'd1);
    tick; a_valid = 1'b0;
    #3 chk("a_rvalid_n1", {63'd0, a_rvalid}, 64'd0);
    tick;
    #3 chk("a_rvalid_n2", {63'd0, a_rvalid}, 64'd1);
    chk("a_rdata", {32'd0, a_rdata}, {32'd0, 32'hDEADBEEF});
    tick;
    #3 chk("a_rvalid_drained", {63'd0, a_rvalid}, 64'd0);
    tick;

    // Partial write of byte 1, read back on B
    a_write(8'h10, 32'h00005500, 4'b0010);
    b_valid = 1'b1; b_addr = 8'h10;
    #3 chk("b_read_ready", {63'd0, b_ready}, 64'd1);
    tick; b_valid = 1'b0;
    #3 chk("b_rvalid_n1", {63'd0, b_rvalid}, 64'd0);
    tick;
    #3 chk("b_rvalid_n2", {63'd0, b_rvalid}, 64'd1);
    chk("b_partial_rdata", {32'd0, b_rdata}, {32'd0, 32'hDEAD55EF});
    tick;

    // Same-cycle write/read collision on 0x20
    a_valid = 1'b1; a_we = 1'b1; a_addr = 8'h20; a_wdata = 32'h12345678; a_wmask = 4'hF;
    b_valid = 1'b1; b_addr = 8'h20;
    #3 chk("coll_ready", {62'd0, a_ready, b_ready}, 64'b10);
    tick; a_valid = 1'b0; a_we = 1'b0;
    #3 chk("coll_retry_ready", {63'd0, b_ready}, 64'd1);
    tick; b_valid = 1'b0;
    #3 chk("coll_rvalid_n1", {63'd0, b_rvalid}, 64'd0);
    tick;
    #3 chk("coll_rvalid_n2", {63'd0, b_rvalid}, 64'd1);
    chk("coll_rdata", {32'd0, b_rdata}, {32'd0, 32'h12345678});
    tick;

    // Backpressure on B: fill 0..7 then stream reads with rready low
    for (int i = 0; i < 8; i++) begin
      pat[i] = 32'hC0DE0000 + 32'(i) * 32'h111;
      a_write(8'(i), pat[i], 4'hF);
    end
    b_rready = 1'b0; bidx = 0;
    for (int c = 0; c < 10; c++) begin
      b_valid = (bidx < 8); b_addr = bidx[7:0];
      #3 if (b_ready) bidx++;
      tick;
    end
    chk("bp_accepted", 64'(bidx), 64'd2);
    b_valid = 1'b1; b_addr = bidx[7:0];
    #3 chk("bp_stalled", {62'd0, b_ready, b_rvalid}, 64'b01);
    tick;
    b_rready = 1'b1; rcv = 0;
    for (int c = 0; c < 60 && rcv < 8; c++) begin
      b_valid = (bidx < 8); b_addr = bidx[7:0];
      #3;
      if (b_rvalid) begin
        chk("bp_order", {32'd0, b_rdata}, {32'd0, pat[rcv & 7]});
        rcv++;
      end
      if (b_ready && b_valid) bidx++;
      tick;
    end
    b_valid = 1'b0;
    chk("bp_received", 64'(rcv), 64'd8);
    chk("bp_issued", 64'(bidx), 64'd8);

    // Reset one cycle after an A read handshake
    a_valid = 1'b1; a_we = 1'b0; a_addr = 8'h10;
    #3 chk("rst_read_ready", {63'd0, a_ready}, 64'd1);
    tick;
    a_valid = 1'b0; rst = 1'b1;
    #3 chk("midrst_pins", {csb0, web0, wmask0, addr0, din0, csb1, addr1,
                           a_rvalid, b_rvalid, a_ready, b_ready, init_done},
           {1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b1, 8'h00, 5'b00000});
    tick;
    rst = 1'b0;
    #3 chk("rerun_init0", {a_rvalid, csb0, web0, addr0, init_done}, {3'b000, 8'h00, 1'b0});
    tick;
    #3 chk("rerun_init1", {a_rvalid, csb0, web0, addr0, init_done}, {3'b000, 8'h01, 1'b0});
    tick;
    #3 chk("rerun_init2", {a_rvalid, csb0, addr0, wmask0}, {2'b00, 8'h02, 4'hF});
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
